// File: rtl/pulse_generator_pkg.sv
// Shared types and defaults for the pulse generator.
// State encoding plus default burst parameters.
package pulse_generator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } pg_state_e;

    localparam int DEF_N_PULSES  = 10;
    localparam int DEF_PULSE_DUR = 2;

endpackage

// File: rtl/pg_phase_counter.sv
// Loadable down-counter timing one HIGH or LOW phase.
// tc is high while the count sits at zero; it never wraps.
module pg_phase_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load on phase entry, otherwise count down and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/pulse_generator.sv
// Burst pulse generator: N_PULSES pulses of PULSE_DUR high / PULSE_DUR low.
// Optional PULSE_GENERATOR_RETRIGGER_EN: enab rise in DONE restarts a burst.
module pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int N_PULSES  = DEF_N_PULSES,
    parameter int PULSE_DUR = DEF_PULSE_DUR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enab,
    output logic                          pulse,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(N_PULSES+1)-1:0] pulse_cnt
);

    localparam int CW = $clog2(N_PULSES + 1);
    localparam int DW = $clog2(PULSE_DUR + 1);

    localparam logic [CW-1:0] N_LIM  = CW'(N_PULSES);
    localparam logic [DW-1:0] DUR_LD = DW'(PULSE_DUR - 1);

    if (N_PULSES < 1 || PULSE_DUR < 1) begin : g_bad_param
        $error("pulse_generator: N_PULSES and PULSE_DUR must be >= 1");
    end

    pg_state_e     state_q;
    pg_state_e     state_d;
    logic          enab_q;
    logic          rise;
    logic          load;
    logic          tc;
    logic [CW-1:0] cnt_d;

    // Edge register resets to 1 so a level held through reset is ignored
    assign rise = enab & ~enab_q;

    pg_phase_counter #(
        .W (DW)
    ) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (DUR_LD),
        .tc       (tc)
    );

    // Next state, pulse count and phase reload
    always_comb begin
        state_d = state_q;
        cnt_d   = pulse_cnt;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CW'(1);
                    load    = 1'b1;
                end
            end
            HIGH: begin
                if (!enab) begin
                    state_d = IDLE;
                end else if (tc) begin
                    if (pulse_cnt < N_LIM) begin
                        state_d = LOW;
                        load    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOW: begin
                if (!enab) begin
                    state_d = IDLE;
                end else if (tc) begin
                    state_d = HIGH;
                    cnt_d   = pulse_cnt + CW'(1);
                    load    = 1'b1;
                end
            end
            DONE: begin
                if (!enab) begin
                    state_d = IDLE;
                end
`ifdef PULSE_GENERATOR_RETRIGGER_EN
                else if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CW'(1);
                    load    = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            enab_q    <= 1'b1;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state_q   <= state_d;
            enab_q    <= enab;
            pulse     <= (state_d == HIGH);
            busy      <= (state_d == HIGH) || (state_d == LOW);
            done      <= (state_d == DONE);
            pulse_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator (10x2 and 1x3 instances).
// Arithmetic burst model checked every cycle plus literal spot checks.
module tb_pulse_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enab = 1'b1;
    logic       p0, b0, d0;
    logic       p1, b1, d1;
    logic [3:0] c0;
    logic [0:0] c1;

    pulse_generator #(
        .N_PULSES  (10),
        .PULSE_DUR (2)
    ) u0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enab      (enab),
        .pulse     (p0),
        .busy      (b0),
        .done      (d0),
        .pulse_cnt (c0)
    );

    pulse_generator #(
        .N_PULSES  (1),
        .PULSE_DUR (3)
    ) u1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enab      (enab),
        .pulse     (p1),
        .busy      (b1),
        .done      (d1),
        .pulse_cnt (c1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_t0 = 0;
    int busy_t1 = 0;

    // Model: mode 0 idle, 1 burst, 2 done; e = edges since burst start
    int mN[2]   = '{10, 1};
    int mD[2]   = '{2, 3};
    int mode[2] = '{0, 0};
    int e[2]    = '{0, 0};
    int mcnt[2] = '{0, 0};
    bit pe[2]   = '{1'b1, 1'b1};

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_p(input int i);
        return (mode[i] == 1 && (e[i] % (2 * mD[i])) < mD[i]) ? 1 : 0;
    endfunction

    function automatic int exp_b(input int i);
        return (mode[i] == 1) ? 1 : 0;
    endfunction

    function automatic int exp_d(input int i);
        return (mode[i] == 2) ? 1 : 0;
    endfunction

    // Model update on each rising edge, cleared by async reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mode[i] = 0;
                e[i]    = 0;
                mcnt[i] = 0;
                pe[i]   = 1'b1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit rise;
                rise  = enab && !pe[i];
                pe[i] = enab;
                case (mode[i])
                    0: begin
                        if (rise) begin
                            mode[i] = 1;
                            e[i]    = 0;
                        end
                    end
                    1: begin
                        if (!enab) begin
                            mode[i] = 0;
                        end else begin
                            e[i]++;
                            if (e[i] == (2 * mN[i] - 1) * mD[i]) mode[i] = 2;
                        end
                    end
                    default: begin
                        if (!enab) begin
                            mode[i] = 0;
                        end
`ifdef PULSE_GENERATOR_RETRIGGER_EN
                        else if (rise) begin
                            mode[i] = 1;
                            e[i]    = 0;
                        end
`endif
                    end
                endcase
                if (mode[i] == 1) mcnt[i] = e[i] / (2 * mD[i]) + 1;
                if (mode[i] == 2) mcnt[i] = mN[i];
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("u0.pulse", int'(p0), exp_p(0));
        chk("u0.busy", int'(b0), exp_b(0));
        chk("u0.done", int'(d0), exp_d(0));
        chk("u0.pulse_cnt", int'(c0), mcnt[0]);
        chk("u1.pulse", int'(p1), exp_p(1));
        chk("u1.busy", int'(b1), exp_b(1));
        chk("u1.done", int'(d1), exp_d(1));
        chk("u1.pulse_cnt", int'(c1), mcnt[1]);
        busy_t0 += int'(b0);
        busy_t1 += int'(b1);
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start_burst();
        enab = 1'b0;
        repeat (2) @(negedge clk);
        enab = 1'b1;
        cyc  = 0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        enab  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.pulse", int'(p0), 0);
        chk("rst.busy", int'(b0), 0);
        chk("rst.done", int'(d0), 0);
        chk("rst.cnt", int'(c0), 0);

        // Level held through reset release must not start a burst
        rst_n = 1'b1;
        seen  = 0;
        repeat (50) begin
            @(negedge clk);
            seen += int'(p0) + int'(p1);
        end
        chk("level_start", seen, 0);

        // Full burst
        start_burst();
        busy_t0 = 0;
        busy_t1 = 0;
        wait_to(1);
        chk("b1.p0", int'(p0), 1);
        chk("b1.c0", int'(c0), 1);
        chk("b1.p1", int'(p1), 1);
        wait_to(3);
        chk("b3.p0", int'(p0), 0);
        chk("b3.p1", int'(p1), 1);
        wait_to(4);
        chk("b4.p1", int'(p1), 0);
        chk("b4.d1", int'(d1), 1);
        wait_to(37);
        chk("b37.p0", int'(p0), 1);
        chk("b37.c0", int'(c0), 10);
        wait_to(38);
        chk("b38.p0", int'(p0), 1);
        wait_to(39);
        chk("b39.p0", int'(p0), 0);
        chk("b39.d0", int'(d0), 1);
        chk("b39.b0", int'(b0), 0);
        chk("b39.c0", int'(c0), 10);
        wait_to(45);
        chk("b45.d0", int'(d0), 1);
        chk("busy_time0", busy_t0, 38);
        chk("busy_time1", busy_t1, 3);

        // Drop for one cycle after done, then rise again
        enab = 1'b0;
        @(negedge clk);
        chk("done_clr", int'(d0), 0);
        chk("done_cnt_hold", int'(c0), 10);
        enab = 1'b1;
        cyc  = 0;
        wait_to(1);
        chk("re.p0", int'(p0), 1);
        chk("re.c0", int'(c0), 1);

        // Abort in HIGH
        start_burst();
        wait_to(10);
        enab = 1'b0;
        wait_to(11);
        chk("ab.p0", int'(p0), 0);
        chk("ab.b0", int'(b0), 0);
        chk("ab.d0", int'(d0), 0);
        chk("ab.c0", int'(c0), 3);

        // Abort in LOW
        start_burst();
        wait_to(3);
        enab = 1'b0;
        wait_to(4);
        chk("abl.p0", int'(p0), 0);
        chk("abl.b0", int'(b0), 0);
        chk("abl.c0", int'(c0), 1);

        // Async reset mid-burst
        start_burst();
        wait_to(5);
        chk("rb.p0", int'(p0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.p0", int'(p0), 0);
        chk("ar.c0", int'(c0), 0);
        chk("ar.b0", int'(b0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(p0) + int'(p1);
        end
        chk("post_rst_quiet", seen, 0);
        start_burst();
        wait_to(1);
        chk("pr.p0", int'(p0), 1);
        chk("pr.c0", int'(c0), 1);
        wait_to(45);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pulse_generator.md
PULSE_GENERATOR -- requirements
Module: pulse_generator

Interface
REQ-001 The block SHALL have parameter N_PULSES, default 10, giving the number of pulses per burst (legal range 1..65535).
REQ-002 The block SHALL have parameter PULSE_DUR, default 2, giving the clock cycles of each high phase and of each low gap (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enab, input, 1 bit: burst request, level, synchronous to clk.
REQ-006 The block SHALL have port pulse, output, 1 bit: the registered pulse train.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: high once a burst has completed, until enab falls.
REQ-009 The block SHALL have port pulse_cnt, output, $clog2(N_PULSES+1) bits: pulses started in the current or last burst.

Function
REQ-010 The FSM SHALL have the states IDLE, HIGH, LOW and DONE, and all outputs SHALL be registered.
REQ-011 In IDLE, a rising edge of enab (prev 0, now 1, both sampled on clk) SHALL move the FSM to HIGH, so that pulse=1 and busy=1 from the next cycle (1-cycle latency), and SHALL set pulse_cnt to 1.
REQ-012 In HIGH, pulse SHALL be 1 for exactly PULSE_DUR cycles.
REQ-013 At the end of HIGH, if pulse_cnt < N_PULSES the FSM SHALL move to LOW; otherwise it SHALL move to DONE.
REQ-014 In LOW, pulse SHALL be 0 for exactly PULSE_DUR cycles, after which the FSM SHALL return to HIGH and increment pulse_cnt.
REQ-015 In DONE, pulse=0, busy=0 and done=1; the FSM SHALL stay in DONE while enab=1 and SHALL go to IDLE (done=0) the cycle after enab=0.
REQ-016 enab=0 sampled in HIGH or LOW SHALL abort the burst: next cycle IDLE, pulse=0, busy=0, done=0, and pulse_cnt held.
REQ-017 enab held high from reset release SHALL NOT start a burst; a 0->1 transition is required.
REQ-018 The burst period SHALL be 2*PULSE_DUR cycles, and total busy time SHALL be (2*N_PULSES-1)*PULSE_DUR cycles.
REQ-019 Duration counters SHALL be $clog2(PULSE_DUR+1) bits wide and SHALL never wrap within a phase.
REQ-020 N_PULSES=1 SHALL produce a single PULSE_DUR-cycle pulse with no LOW phase.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, pulse=0, busy=0, done=0, pulse_cnt=0, counters=0, and enab edge register=1.
REQ-022 Reset asserted mid-burst SHALL terminate it, and pulse SHALL drop without waiting for a clk edge.
REQ-023 Reset deassertion SHALL be the only asynchronous-to-synchronous boundary, and the integrator SHALL synchronize it.

Configuration
REQ-024 With PULSE_GENERATOR_RETRIGGER_EN defined, an enab rising edge in DONE SHALL restart a burst directly (HIGH next cycle, pulse_cnt=1, done=0).
REQ-025 With PULSE_GENERATOR_RETRIGGER_EN defined, a rising edge during HIGH or LOW (enab 1->0->1, which first aborts) SHALL start a burst from IDLE as normal.
REQ-026 Without PULSE_GENERATOR_RETRIGGER_EN, DONE SHALL exit only via enab=0, per REQ-015.

Structure
REQ-027 Package pulse_generator_pkg SHALL hold the state enum typedef (IDLE, HIGH, LOW, DONE) and the default constants DEF_N_PULSES=10 and DEF_PULSE_DUR=2.
REQ-028 One sub-module, pg_phase_counter, SHALL provide a loadable down-counter with a terminal-count flag, used for the HIGH/LOW durations.
REQ-029 An elaboration-time check SHALL reject N_PULSES<1 or PULSE_DUR<1.

Verification (N_PULSES=10, PULSE_DUR=2; cycle 0 = first edge sampling enab=1)
REQ-030 Basic burst: enab 0->1 held -> pulse=1 on cycles 1-2+4k and 0 on cycles 3-4+4k for k=0..9; last high cycles 37-38; done=1 from cycle 39; pulse_cnt=10.
REQ-031 Abort: enab drops at cycle 10 -> pulse=0, busy=0 at cycle 11; pulse_cnt=3; done=0.
REQ-032 Reset mid-burst: rst_n=0 at cycle 5.5 -> pulse=0, pulse_cnt=0 immediately; no pulse after release until a new enab rise.
REQ-033 Level start: enab=1 through reset release -> pulse stays 0 for 50 cycles.
REQ-034 Single pulse (N_PULSES=1, PULSE_DUR=3): pulse high on cycles 1-3 only; done at cycle 4.
REQ-035 Retrigger (macro defined): enab pulsed 0 for one cycle after done, then rise -> new burst starts one cycle after the rise, pulse_cnt restarts at 1.
